ifu_inst_queue: RTL
===================

// Module: ifu_inst_queue
// PURPOSE
//  Instruction queue between the SRAM fetch stage and the decode stage (IDU).
//  Buffers {pc, inst} pairs with valid/ready handshakes on both sides, so fetch
//  keeps running while decode stalls. flush drops all queued entries on a
//  redirect (branch/jump/exception).
// PARAMETERS
//  DEPTH   4    entries; power of two, >= 2
//  XLEN    32   pc and instruction width
// PORTS
//  clk        in   1           clock; all logic on posedge
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           fetch offers {in_pc, in_inst}
//  in_ready   out  1           queue accepts this cycle
//  in_pc      in   XLEN        pc of offered instruction
//  in_inst    in   XLEN        offered instruction word
//  out_valid  out  1           head entry valid toward decode
//  out_ready  in   1           decode consumes head this cycle
//  out_pc     out  XLEN        head pc
//  out_inst   out  XLEN        head instruction
//  flush      in   1           discard all entries
//  count      out  clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - One clock, clk. rst is synchronous, active-high, sampled on posedge clk.
//  - Reset: pointers 0, count 0, out_valid 0, in_ready 1, storage cleared so
//    out_pc = out_inst = 0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both take
//    effect on the same posedge.
//  - in_ready = !full & !flush. No bypass when full: a pop in the same cycle
//    does not free a slot for a push in that cycle.
//  - out_valid = !empty. out_pc/out_inst = storage[rd_ptr]. No combinational
//    path from in_* to out_*.
//  - Latency: a push into an empty queue is visible at out_* on the next
//    cycle. Throughput is 1 entry per cycle when neither side stalls.
//  - Pointers: wr_ptr/rd_ptr are clog2(DEPTH)+1 bits, with an extra wrap bit.
//    full = (addr equal & wrap differ). empty = (ptrs equal).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//    It never exceeds DEPTH and never underflows.
//  - Push and pop together when not full and not empty: count unchanged, both
//    pointers advance.
//  - Push and pop together when empty: impossible, because out_valid = 0.
//  - Priority is rst > flush > push/pop. flush=1: on the next edge both
//    pointers reset to 0 and count goes to 0. A concurrent in_valid is
//    dropped, because in_ready = 0. A concurrent out_ready is ignored.
//    Storage is not cleared.
//  - Holding flush for several cycles keeps the queue empty and in_ready = 0.
//  - Data stability: while out_valid & !out_ready, out_pc/out_inst must not
//    change.
//  - Upstream obeys the protocol: in_pc/in_inst stay stable while
//    in_valid & !in_ready.
// STRUCTURE
//  - Shared package: XLEN, RESET_PC = 32'h8000_0000, NOP = 32'h0000_0013,
//    and a typedef for the {pc, inst} entry struct.
//  - One sub-module: queue_ptr (pointer/wrap-bit counter with inc and clear),
//    instantiated twice, for rd and wr.
//  - Storage is a flop array of DEPTH entries, no SRAM macro. Write on push.
// TESTING (DEPTH=4)
//  1. rst 2 cycles -> out_valid=0, in_ready=1, count=0, out_inst=0.
//  2. out_ready=0; push pc 0x80000000..0x8000000C with inst 0x11..0x44 ->
//     count=4, in_ready=0. A 5th push is not accepted. Then out_ready=1
//     drains 0x11,0x22,0x33,0x44 in order, paired with their pcs.
//  3. Steady state: count=2, in_valid=out_ready=1 for 10 cycles with
//     incrementing inst -> count stays 2. Output sequence has no gaps or
//     duplicates, and pointers wrap twice.
//  4. Full queue, in_valid=1, out_ready=1, flush=1 for 1 cycle -> next cycle
//     count=0, out_valid=0. Offered entry is absent. Next push 0xAA appears
//     1 cycle later.
//  5. count=3, assert rst mid-stream with in_valid=1 -> next cycle count=0,
//     out_valid=0, out_inst=0. No entry was written in the reset cycle.
//  6. out_valid=1, out_ready=0 for 5 cycles while pushes continue ->
//     out_pc/out_inst unchanged throughout (assertion).

Source files
------------

// File: rtl/ifu_inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package ifu_inst_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/ifu_inst_queue_ptr.sv
// Queue pointer with an extra wrap bit; clr returns it to zero, inc advances it.
module queue_ptr #(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] ptr
);

  logic [AW:0] ptr_r;

  // pointer register: reset/clear to zero, otherwise advance on inc
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {(AW+1){1'b0}};
    end else if (clr) begin
      ptr_r <= {(AW+1){1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/ifu_inst_queue.sv
// Instruction queue between fetch and decode: buffers {pc, inst} pairs,
// valid/ready on both sides, flush drops every queued entry.
module ifu_inst_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = ifu_inst_queue_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  import ifu_inst_queue_pkg::iq_entry_t;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_s;
  logic [AW:0] rd_ptr_s;
  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic [AW:0] count_r;
  iq_entry_t   mem_r [DEPTH];
  iq_entry_t   head_s;

  // Same slot with opposite wrap bits means every slot is occupied.
  assign full_s  = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) && (wr_ptr_s[AW] != rd_ptr_s[AW]);
  assign empty_s = (wr_ptr_s == rd_ptr_s);

  // A pop never frees a slot for a same-cycle push; flush masks both sides.
  assign in_ready  = !full_s && !flush;
  assign out_valid = !empty_s;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready && !flush;

  queue_ptr #(.AW(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_s),
    .ptr (wr_ptr_s)
  );

  queue_ptr #(.AW(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_s),
    .ptr (rd_ptr_s)
  );

  // occupancy counter tracking push/pop imbalance
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      count_r <= {(AW+1){1'b0}};
    end else if (push_s && !pop_s) begin
      count_r <= count_r + {{AW{1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      count_r <= count_r - {{AW{1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // entry storage: cleared only by reset, written on push
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(iq_entry_t){1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_s[AW-1:0]] <= '{pc: in_pc, inst: in_inst};
    end else begin
      mem_r <= mem_r;
    end
  end

  assign head_s   = mem_r[rd_ptr_s[AW-1:0]];
  assign out_pc   = head_s.pc;
  assign out_inst = head_s.inst;
  assign count    = count_r;

endmodule
